// File: rtl/rgb_pwm_ctrl.sv
// rgb_pwm_ctrl
// Multi-channel LED PWM controller feeding the SB_RGBA_DRV PWM pins.
// Each channel has a duty level and one of four modes: off, static, blink
// or breathe. A new brightness is taken only at a period boundary, so each
// PWM period is complete and free of glitches. Each channel's active-low pad
// enable is synchronised and debounced before it gates the output.
//
// Ports:
//   clk      system clock, all logic on posedge
//   rst      synchronous, active-high reset
//   mode     per channel [2i+1:2i]: 00 off, 01 static, 10 blink, 11 breathe
//   duty     per channel duty level, slice i at [PWM_BITS*(i+1)-1:PWM_BITS*i]
//   en_n     raw asynchronous pad enables, active-low
//   enabled  debounced enable state per channel
//   pwm      registered PWM drive per channel
module rgb_pwm_ctrl #(
   parameter int CHANNELS   = 3,
   parameter int PWM_BITS   = 8,
   parameter int BLINK_BITS = 23,
   parameter int STEP_BITS  = 16,
   parameter int DEB_BITS   = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [2*CHANNELS-1:0]        mode,
   input  logic [PWM_BITS*CHANNELS-1:0] duty,
   input  logic [CHANNELS-1:0]          en_n,
   output logic [CHANNELS-1:0]          enabled,
   output logic [CHANNELS-1:0]          pwm
);

   typedef enum logic [1:0] {
      MODE_OFF     = 2'b00,
      MODE_STATIC  = 2'b01,
      MODE_BLINK   = 2'b10,
      MODE_BREATHE = 2'b11
   } mode_e;

   localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

   // Shared timebase
   logic [PWM_BITS-1:0]   pcnt;
   logic [BLINK_BITS-1:0] bcnt;
   logic [STEP_BITS-1:0]  pre;
   logic [PWM_BITS-1:0]   ramp;
   logic                  dir;   // 0 = ramping up

   // Per-channel state
   logic [PWM_BITS-1:0]   lvl    [CHANNELS];
   logic [PWM_BITS-1:0]   target [CHANNELS];
   logic [DEB_BITS-1:0]   dc     [CHANNELS];
   logic [CHANNELS-1:0]   sync1;
   logic [CHANNELS-1:0]   sync2;

   // Target brightness per channel. The registered ramp and blink counter
   // are used, so a sample taken on a step or toggle edge sees the old value.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         // NOTE: assign a default first so every path drives target and no latch is inferred.
         target[i] = '0;
         case (mode_e'(mode[2*i +: 2]))
            MODE_STATIC:  target[i] = duty[PWM_BITS*i +: PWM_BITS];
            MODE_BLINK:   if (bcnt[BLINK_BITS-1]) target[i] = duty[PWM_BITS*i +: PWM_BITS];
            MODE_BREATHE: target[i] = (ramp < duty[PWM_BITS*i +: PWM_BITS]) ?
                                      ramp : duty[PWM_BITS*i +: PWM_BITS];
            default:      target[i] = '0;
         endcase
      end
   end

   // Free-running counters and the breathe ramp. The ramp saturates at both
   // ends: the step that reaches a limit only flips the direction.
   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         pcnt <= '0;
         bcnt <= '0;
         pre  <= '0;
         ramp <= '0;
         dir  <= 1'b0;
      end else begin
         pcnt <= pcnt + 1'b1;
         bcnt <= bcnt + 1'b1;
         pre  <= pre + 1'b1;
         if (pre == '1) begin
            if (!dir) begin
               if (ramp == PWM_MAX) dir  <= 1'b1;
               else                 ramp <= ramp + 1'b1;
            end else begin
               if (ramp == '0)      dir  <= 1'b0;
               else                 ramp <= ramp - 1'b1;
            end
         end
      end
   end

   // Shadow levels, PWM outputs, enable synchroniser and debounce
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= '0;
         sync2   <= '0;
         enabled <= '0;
         pwm     <= '0;
         // NOTE: lvl and dc are per-channel flops, not a RAM, so they are reset to give a defined first period.
         for (int i = 0; i < CHANNELS; i++) begin
            lvl[i] <= '0;
            dc[i]  <= '0;
         end
      end else begin
         sync1 <= ~en_n;
         sync2 <= sync1;
         for (int i = 0; i < CHANNELS; i++) begin
            // Latched on the last count so the new level starts the next period.
            if (pcnt == PWM_MAX) lvl[i] <= target[i];
            pwm[i] <= (pcnt < lvl[i]) & enabled[i];

            // Any return to equality restarts the stability count.
            if (sync2[i] == enabled[i]) begin
               dc[i] <= '0;
            end else if (dc[i] == '1) begin
               enabled[i] <= sync2[i];
               dc[i]      <= '0;
            end else begin
               dc[i] <= dc[i] + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
module tb_rgb_pwm_ctrl;

   localparam int NCH        = 3;
   localparam int PB         = 4;
   localparam int PERIOD     = 16;   // 2^PWM_BITS
   localparam int HALF_BLINK = 32;   // 2^(BLINK_BITS-1)
   localparam int STEP       = 4;    // 2^STEP_BITS
   localparam int DEB        = 8;    // 2^DEB_BITS

   logic                clk;
   logic                rst;
   logic [2*NCH-1:0]    mode;
   logic [PB*NCH-1:0]   duty;
   logic [NCH-1:0]      en_n;
   logic [NCH-1:0]      enabled;
   logic [NCH-1:0]      pwm;

   rgb_pwm_ctrl #(
      .CHANNELS   (NCH),
      .PWM_BITS   (PB),
      .BLINK_BITS (6),
      .STEP_BITS  (2),
      .DEB_BITS   (3)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .mode    (mode),
      .duty    (duty),
      .en_n    (en_n),
      .enabled (enabled),
      .pwm     (pwm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [NCH-1:0] pwm;
      logic [NCH-1:0] en;
   } exp_t;

   exp_t exp_q[$];

   int m_n;            // clock edges since reset released = current cycle index
   int m_lvl [NCH];
   bit m_en  [NCH];
   int m_run [NCH];    // consecutive cycles the synchronised input differed
   bit m_s1  [NCH];
   bit m_s2  [NCH];
   bit m_pwm [NCH];

   // Triangle wave: 0..15, hold 15 one step, 14..0, hold 0 one step, repeat.
   function automatic int ramp_at(input int n);
      int k;
      k = (n / STEP) % 32;
      return (k < 16) ? k : 31 - k;
   endfunction

   function automatic int target_at(input int n, input int md, input int d);
      case (md)
         1:       return d;
         2:       return (((n / HALF_BLINK) % 2) == 1) ? d : 0;
         3:       return (ramp_at(n) < d) ? ramp_at(n) : d;
         default: return 0;
      endcase
   endfunction

   task automatic model_step();
      exp_t e;
      if (rst) begin
         m_n = 0;
         for (int c = 0; c < NCH; c++) begin
            m_lvl[c] = 0; m_en[c] = 0; m_run[c] = 0;
            m_s1[c] = 0;  m_s2[c] = 0; m_pwm[c] = 0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            m_pwm[c] = ((m_n % PERIOD) < m_lvl[c]) && m_en[c];
            if ((m_n % PERIOD) == PERIOD - 1)
               m_lvl[c] = target_at(m_n, int'(mode[2*c +: 2]), int'(duty[PB*c +: PB]));
            if (m_s2[c] != m_en[c]) begin
               m_run[c]++;
               if (m_run[c] == DEB) begin
                  m_en[c]  = m_s2[c];
                  m_run[c] = 0;
               end
            end else begin
               m_run[c] = 0;
            end
            m_s2[c] = m_s1[c];
            m_s1[c] = !en_n[c];
         end
         m_n++;
      end
      for (int c = 0; c < NCH; c++) begin
         e.pwm[c] = m_pwm[c];
         e.en[c]  = m_en[c];
      end
      exp_q.push_back(e);
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // ---------------- monitor ----------------
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("pwm", 32'(pwm), 32'(e.pwm));
         check("enabled", 32'(enabled), 32'(e.en));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cycles(input int k);
      repeat (k) @(negedge clk);
      #1;
   endtask

   task automatic wait_phase(input int ph);
      int g = 0;
      while ((m_n % PERIOD) != ph && g < 40) begin
         cycles(1);
         g++;
      end
      if (g >= 40) check("phase_timeout", g, 0);
   endtask

   // High cycles of one full period (output lags the counter by one cycle).
   task automatic period_count(input int ch, output int cnt);
      cnt = 0;
      wait_phase(1);
      for (int k = 0; k < PERIOD; k++) begin
         cnt += int'(pwm[ch]);
         cycles(1);
      end
   endtask

   task automatic count_high(input int ch, input string name, input int exp_cnt);
      int cnt;
      period_count(ch, cnt);
      check(name, cnt, exp_cnt);
   endtask

   task automatic random_phase();
      int ch;
      for (int it = 0; it < 60; it++) begin
         ch = $urandom_range(0, NCH - 1);
         case ($urandom_range(0, 3))
            0: mode[2*ch +: 2] = 2'($urandom_range(0, 3));
            1: duty[PB*ch +: PB] = 4'($urandom_range(0, 15));
            2: en_n[ch] = ~en_n[ch];
            default: begin
               en_n[ch] = ~en_n[ch];
               cycles($urandom_range(1, 10));
               en_n[ch] = ~en_n[ch];
            end
         endcase
         cycles($urandom_range(1, 30));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cnt;
      int mx;
      rst  = 1'b1;
      mode = '0;
      duty = '0;
      en_n = '1;
      cycles(3);
      rst = 1'b0;

      // Static duty and its extremes
      mode[1:0] = 2'b01;
      duty[3:0] = 4'd5;
      en_n[0]   = 1'b0;
      cycles(40);
      count_high(0, "static5", 5);
      duty[3:0] = 4'd0;
      cycles(32);
      count_high(0, "duty0", 0);
      duty[3:0] = 4'd15;
      cycles(32);
      count_high(0, "duty15", 15);

      // Mid-period duty change takes effect at the next period
      duty[3:0] = 4'd5;
      cycles(32);
      wait_phase(7);
      duty[3:0] = 4'd12;
      count_high(0, "update12", 12);

      // Debounce: short pulse ignored, bounce restarts, long hold accepted
      mode[3:2] = 2'b01;
      duty[7:4] = 4'd8;
      en_n[1]   = 1'b0;
      cycles(6);
      en_n[1]   = 1'b1;
      cycles(12);
      check("short_pulse", 32'(enabled[1]), 0);
      en_n[1] = 1'b0;
      cycles(4);
      en_n[1] = 1'b1;
      cycles(1);
      en_n[1] = 1'b0;
      cycles(20);
      check("long_hold", 32'(enabled[1]), 1);

      // Blink on ch2 at full duty
      mode[5:4]  = 2'b10;
      duty[11:8] = 4'd15;
      en_n[2]    = 1'b0;
      cycles(200);

      // Breathe on ch0 saturates at duty 10
      mode[1:0] = 2'b11;
      duty[3:0] = 4'd10;
      cycles(40);
      mx = 0;
      for (int p = 0; p < 8; p++) begin
         period_count(0, cnt);
         if (cnt > mx) mx = cnt;
      end
      check("breathe_max", mx, 10);

      // Reset mid-period while pwm[0] is high
      mode[1:0] = 2'b01;
      duty[3:0] = 4'd15;
      cycles(40);
      wait_phase(9);
      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      check("rst_pwm", 32'(pwm), 0);
      check("rst_en", 32'(enabled), 0);
      cycles(40);
      count_high(0, "post_rst", 15);

      random_phase();

      cycles(3);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
